dm_bank: RTL and testbench
==========================

Name: dm_bank

Overview:
- Parametrised, byte-addressed data memory for the RISC-V CPU load/store stage.
- Successor to the fixed 128-byte single-cycle data memory.
- Adds configurable depth, address width and access latency, a valid/ready request/response handshake, and true byte-lane addressing from addr[1:0].
- Reports misaligned, out-of-range and illegal-type accesses as error responses instead of corrupting memory, so a multicycle or pipelined core can stall on it.

Parameters:
- DEPTH, 1024, memory size in bytes; power of two, >= 4.
- AW, 32, width of req_addr in bits.
- LAT, 2, cycles from request accept to response valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_type  input  3  access type, encoded per DM_* constants.
- req_addr  input  AW  full byte address, including bits [1:0].
- req_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
- req_pc  input  32  PC of the issuing instruction; used only for trace.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  load data after sign/zero extension; 0 for stores and errors.
- rsp_err  output  1  access rejected; memory not modified.

Behaviour:
- Type encoding: DM_WORD=3'b000, DM_HALF=3'b001, DM_HALF_U=3'b010, DM_BYTE=3'b011, DM_BYTE_U=3'b100. Codes 101..111 are illegal.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/type/addr/wdata/pc, load cnt=LAT-1, go to WAIT.
  - WAIT: decrement cnt each cycle. When cnt==0, perform the access, register the response, go to RESP.
  - RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready, then go to IDLE.
- No request overlap: req_ready=0 in WAIT and RESP.
- Latency: with the accept edge as edge 0, rsp_valid rises on edge LAT. The earliest next accept is the edge after the response handshake.
- Error check, performed at the access edge. The access is an error if any of these hold:
  - illegal type;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr + size - 1 >= DEPTH.
- On error: rsp_err=1, rsp_rdata=0, no write.
- Little-endian layout: byte k of a word lives at address addr+k.
- Stores write only the 1, 2 or 4 addressed bytes; all other bytes are unchanged.
- Loads:
  - DM_HALF and DM_BYTE sign-extend from bit 15 and bit 7 respectively.
  - The _U variants zero-extend.
- Store response: rsp_valid with rsp_rdata=0, rsp_err=0.
- Reset: state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, cnt=0; req_ready=1 as soon as rst deasserts.
- Memory array is not reset; contents are undefined at power-up.
- Reset mid-operation: an in-flight transaction is dropped. A store still in WAIT never commits.
- rsp_ready held high in RESP: the handshake completes in the first RESP cycle and IDLE follows on the next edge.
- Inputs are ignored outside IDLE.

Optional Feature:
- DM_TRACE_EN defined: on every committed store, $display prints "pc = %h: dataaddr = %h, memdata = %h". Fields are the latched pc, the full byte address, and the stored data masked to the access size. Errored stores print "pc = %h: dm error addr = %h".
- DM_TRACE_EN undefined: no display code is compiled; RTL behaviour is identical.

Decomposition:
- Package dm_pkg holds:
  - the DM_* type codes;
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - a function returning access size in bytes from type (0 for illegal).
- Sub-module dm_lane: combinational byte-lane unit. It takes type, addr[1:0] and the 4-byte memory word, and produces the per-byte write enables, the positioned write data, and the extended read data.
- dm_bank holds the FSM, latency counter, error check and array.

Test Plan:
- LAT=2: store DM_WORD addr 0x10 data 0xDEADBEEF, then load DM_WORD 0x10. Required: rsp_valid on edge 2 after each accept, rdata=0xDEADBEEF, err=0.
- Store DM_BYTE 0x80 to addr 0x13 over 0x00000000, then run four loads:
  - DM_BYTE 0x13 → 0xFFFFFF80;
  - DM_BYTE_U 0x13 → 0x00000080;
  - DM_WORD 0x10 → 0x80000000;
  - DM_HALF 0x12 → 0xFFFF8000.
- Load DM_WORD at 0x22, store DM_HALF at 0x31, and use type 3'b111. Each must give rsp_err=1 and rdata=0, and a following load of 0x30 must show it unchanged.
- Store at DEPTH-2 with DM_WORD, then DM_HALF at DEPTH-2. Required: the first gives err=1; the second gives err=0 and writes.
- Hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid and rsp_rdata stable, req_ready=0, and a second req_valid is not accepted until after the handshake.
- Assert rst during WAIT of a store to 0x40 = 0x12345678 (prior value 0x0). After reset, a load of 0x40 must return 0x00000000 and rsp_valid must be 0 immediately after reset.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - dm_bank shared types: access type codes, FSM state encoding, access size helper
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Access size in bytes; 0 marks an illegal type code.
    function automatic logic [2:0] dm_size(input logic [2:0] t);
        case (t)
            DM_WORD:             dm_size = 3'd4;
            DM_HALF, DM_HALF_U:  dm_size = 3'd2;
            DM_BYTE, DM_BYTE_U:  dm_size = 3'd1;
            default:             dm_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane.sv
// rtl/dm_lane.sv - combinational byte-lane unit: write enables, positioned write data, extended read data
module dm_lane
    import dm_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  shamt;
    logic [31:0] rshift;

    assign shamt   = {addr_lo_i, 3'b000};
    assign wword_o = wdata_i << shamt;
    assign rshift  = rword_i >> shamt;

    // Lane enables and load extension both follow the access type; illegal types touch nothing.
    always_comb begin
        be_o    = 4'b0000;
        rdata_o = 32'h0;
        case (type_i)
            DM_WORD: begin
                be_o    = 4'b1111;
                rdata_o = rshift;
            end
            DM_HALF: begin
                be_o    = 4'b0011 << addr_lo_i;
                rdata_o = {{16{rshift[15]}}, rshift[15:0]};
            end
            DM_HALF_U: begin
                be_o    = 4'b0011 << addr_lo_i;
                rdata_o = {16'h0, rshift[15:0]};
            end
            DM_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                rdata_o = {{24{rshift[7]}}, rshift[7:0]};
            end
            DM_BYTE_U: begin
                be_o    = 4'b0001 << addr_lo_i;
                rdata_o = {24'h0, rshift[7:0]};
            end
            default: begin
                be_o    = 4'b0000;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dm_bank.sv
// rtl/dm_bank.sv - byte-addressed data memory with valid/ready handshake and LAT-cycle access; trace on DM_TRACE_EN
module dm_bank
    import dm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 32,
    parameter int LAT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_type,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [31:0]   req_pc,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);

    localparam int IW = $clog2(DEPTH);

    dm_state_e     state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [2:0]    type_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          latch_en;

    logic [7:0]    mem [DEPTH];
    logic [IW-1:0] base;
    logic [31:0]   rword, wword, lane_rdata;
    logic [3:0]    be;
    logic [2:0]    size;
    logic [AW:0]   last_addr;
    logic          misaligned, access_err, access, commit;

    assign base  = addr_q[IW-1:0] & ~(IW'(3));
    assign rword = {mem[base + IW'(3)], mem[base + IW'(2)], mem[base + IW'(1)], mem[base]};

    dm_lane u_lane (
        .type_i    (type_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rword_i   (rword),
        .be_o      (be),
        .wword_o   (wword),
        .rdata_o   (lane_rdata)
    );

    // Range check is done one bit wider than the address so the top of the space cannot wrap.
    assign size       = dm_size(type_q);
    assign last_addr  = {1'b0, addr_q} + (AW+1)'(size) - (AW+1)'(1);
    assign misaligned = ((type_q == DM_HALF || type_q == DM_HALF_U) && addr_q[0]) ||
                        (type_q == DM_WORD && addr_q[1:0] != 2'b00);
    assign access_err = (size == 3'd0) || misaligned || (last_addr >= (AW+1)'(DEPTH));
    assign access     = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign commit     = access && we_q && !access_err;

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;

    // Next-state logic: accept in IDLE, count down in WAIT, hold the response until handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    latch_en = 1'b1;
                    cnt_d    = 4'(LAT - 1);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = (we_q || access_err) ? 32'h0 : lane_rdata;
                    err_d   = access_err;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and request registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            type_q  <= DM_WORD;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (latch_en) begin
                we_q    <= req_we;
                type_q  <= req_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Array write: only the addressed lanes of a store that passed the error check.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[base + IW'(k)] <= wword[8*k +: 8];
            end
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] pc_q;
    logic [31:0] trace_mask;

    assign trace_mask = (size == 3'd1) ? 32'h0000_00FF :
                        (size == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    // Trace PC follows the request it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           pc_q <= 32'h0;
        else if (latch_en) pc_q <= req_pc;
    end

    // Print one line per store as it reaches the access edge.
    always @(posedge clk) begin
        if (!rst && access && we_q) begin
            if (access_err) $display("pc = %h: dm error addr = %h", pc_q, addr_q);
            else            $display("pc = %h: dataaddr = %h, memdata = %h", pc_q, addr_q, wdata_q & trace_mask);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_bank.sv
// tb/tb_dm_bank.sv - directed table-driven bench for dm_bank (DEPTH=1024, LAT=2)
module tb_dm_bank;

    localparam logic [2:0] W  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] HU = 3'b010;
    localparam logic [2:0] B  = 3'b011;
    localparam logic [2:0] BU = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_pc = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_bank #(.DEPTH(1024), .AW(32), .LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction: accept, count edges to rsp_valid, then handshake.
    task automatic do_req(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        @(negedge clk);
        req_we = we; req_type = typ; req_addr = addr; req_wdata = wdata;
        req_pc = 32'h1000 + addr; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;
    int          n;

    initial begin
        n = 0;
        vecs[n++] = '{1'b1, W,  32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[n++] = '{1'b0, W,  32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[n++] = '{1'b1, W,  32'h010, 32'h00000000, 32'h0,        1'b0};
        vecs[n++] = '{1'b1, B,  32'h013, 32'h00000080, 32'h0,        1'b0};
        vecs[n++] = '{1'b0, B,  32'h013, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[n++] = '{1'b0, BU, 32'h013, 32'h0,        32'h00000080, 1'b0};
        vecs[n++] = '{1'b0, W,  32'h010, 32'h0,        32'h80000000, 1'b0};
        vecs[n++] = '{1'b0, H,  32'h012, 32'h0,        32'hFFFF8000, 1'b0};
        vecs[n++] = '{1'b1, W,  32'h030, 32'hA5A55A5A, 32'h0,        1'b0};
        vecs[n++] = '{1'b0, W,  32'h022, 32'h0,        32'h0,        1'b1};
        vecs[n++] = '{1'b1, H,  32'h031, 32'h00001234, 32'h0,        1'b1};
        vecs[n++] = '{1'b1, 3'b111, 32'h030, 32'hFFFFFFFF, 32'h0,    1'b1};
        vecs[n++] = '{1'b0, W,  32'h030, 32'h0,        32'hA5A55A5A, 1'b0};
        vecs[n++] = '{1'b1, W,  32'h3FE, 32'h11112222, 32'h0,        1'b1};
        vecs[n++] = '{1'b1, H,  32'h3FE, 32'h0000BEEF, 32'h0,        1'b0};
        vecs[n++] = '{1'b0, HU, 32'h3FE, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[n++] = '{1'b0, B,  32'h3FF, 32'h0,        32'hFFFFFFBE, 1'b0};
        vecs[n++] = '{1'b0, H,  32'h3FF, 32'h0,        32'h0,        1'b1};
        vecs[n++] = '{1'b0, B,  32'h400, 32'h0,        32'h0,        1'b1};
        vecs[n++] = '{1'b0, H,  32'h3FD, 32'h0,        32'h0,        1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err",   32'(rsp_err), 32'd0);

        // Directed table
        for (int i = 0; i < n; i++) begin
            do_req(vecs[i].we, vecs[i].typ, vecs[i].addr, vecs[i].wdata, rd, er, lt);
            chk($sformatf("v%0d latency", i), 32'(lt), 32'd2);
            chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Backpressure: response held 5 cycles while a second request waits
        @(negedge clk);
        req_we = 1'b0; req_type = W; req_addr = 32'h010; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_type = W; req_addr = 32'h030;
        lt = 0;
        while (!rsp_valid && lt < 50) begin
            @(posedge clk); #1;
            lt++;
        end
        chk("bp latency", 32'(lt), 32'd2);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp hold%0d valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp hold%0d rdata", c), rsp_rdata, 32'h80000000);
            chk($sformatf("bp hold%0d req_ready", c), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp after hs valid", 32'(rsp_valid), 32'd0);
        chk("bp after hs req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp second accepted", 32'(req_ready), 32'd0);
        lt = 0;
        while (!rsp_valid && lt < 50) begin
            @(posedge clk); #1;
            lt++;
        end
        chk("bp second latency", 32'(lt), 32'd2);
        chk("bp second rdata", rsp_rdata, 32'hA5A55A5A);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during WAIT of a store: the store must not commit
        do_req(1'b1, W, 32'h040, 32'h00000000, rd, er, lt);
        @(negedge clk);
        req_we = 1'b1; req_type = W; req_addr = 32'h040; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst mid req_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, W, 32'h040, 32'h0, rd, er, lt);
        chk("rst mid load rdata", rd, 32'h00000000);
        chk("rst mid load err", 32'(er), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
